regwr_arbiter: RTL and testbench
================================

Name: regwr_arbiter

Overview:
- Single-write-port scheduler for the processor register bank (R0-R15 general, R16 = RET).
- Shares the bank's one write port between two writeback sources: the ALU result path and the memory load path.
- Uses valid/ready handshakes and round-robin arbitration.
- Output is registered and drives the bank's wrReg/destReg/wrData inputs directly.

Parameters:
NUM_REGS, 17, number of implemented registers; legal destinations are 0..NUM_REGS-1
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_dest  input  AW  ALU destination register
alu_data  input  DW  ALU writeback data
alu_ready  output  1  ALU request accepted this cycle
ld_valid  input  1  load writeback request
ld_dest  input  AW  load destination register
ld_data  input  DW  load writeback data
ld_ready  output  1  load request accepted this cycle
wrReg  output  1  register bank write enable
destReg  output  AW  register bank write address
wrData  output  DW  register bank write data
bad_dest  output  1  sticky flag: a destination >= NUM_REGS was accepted
last_grant  output  1  most recent grant: 0 = ALU, 1 = load

Behaviour:
- Reset values (asynchronous, effective immediately on rst rising):
  - wrReg=0, destReg=0, wrData=0, bad_dest=0.
  - last_grant=1, so the ALU wins the first tie.
- Grant logic (combinational from inputs and last_grant):
  - grant_alu = alu_valid && (!ld_valid || last_grant==1).
  - grant_ld = ld_valid && !grant_alu.
  - alu_ready = grant_alu; ld_ready = grant_ld. At most one ready is high per cycle.
  - Ready never rises without the corresponding valid.
- Handshake:
  - A transfer occurs when valid && ready on a rising clk edge.
  - A requester holds valid, dest and data stable until it sees ready.
  - A losing requester simply stays pending; nothing is dropped.
- last_grant updates only on a transfer cycle, to the winner; otherwise it holds.
- Latency: the transfer in cycle N produces wrReg/destReg/wrData in cycle N+1, registered.
  - wrReg is high exactly one cycle per effective write.
  - With no transfer in cycle N, wrReg=0 in N+1 and destReg/wrData hold their last values.
- Destination rules on a transfer:
  - dest == 0: accepted (ready high), wrReg stays 0. R0 is never written.
  - dest >= NUM_REGS: accepted, wrReg stays 0, bad_dest set to 1. bad_dest stays 1 until rst.
  - 1 <= dest < NUM_REGS: normal write. Dest 16 (RET) is legal.
- Throughput:
  - One write per cycle sustained.
  - With both sources continuously valid, grants alternate ALU, LD, ALU, LD...
  - Worst-case wait for either source is 1 cycle.
- Ordering:
  - Same-destination writes from both sources in the same cycle land in grant order.
  - The later grant's data is the final register value.
- Reset mid-operation: a transfer accepted in the cycle rst asserts is discarded; no wrReg pulse follows.
- While rst is high: both ready outputs are 0.

Optional Feature:
REGWR_FWD_EN
- With the macro:
  - Adds inputs fwd_rs[AW] and fwd_rt[AW], and outputs fwd_hit1, fwd_hit2, fwd_data[DW].
  - fwd_hit1 = wrReg && destReg==fwd_rs && fwd_rs!=0; fwd_hit2 is the same test against fwd_rt.
  - fwd_data = wrData. All combinational.
  - Lets readers bypass the write happening this cycle.
- Without the macro: these ports do not exist and there is no compare logic.

Test Plan:
- rst pulse mid-run -> wrReg=0, destReg=0, wrData=0, bad_dest=0, last_grant=1 immediately; alu_ready=ld_ready=0 while rst=1.
- alu_valid=1, alu_dest=3, alu_data=32'h1234 for one cycle -> alu_ready=1 same cycle; next cycle wrReg=1, destReg=3, wrData=32'h1234; following cycle wrReg=0.
- Both valid and held (ALU dest 5, data 32'hA; LD dest 5, data 32'hB) -> ALU granted cycle N, LD cycle N+1; writes to R5 of A then B on consecutive cycles; last_grant=1. Continuous valids -> grants strictly alternate.
- ld_valid=1, ld_dest=0, ld_data=32'hFFFF -> ld_ready=1; wrReg stays 0; bad_dest stays 0.
- alu_dest=20 accepted -> wrReg=0, bad_dest=1; bad_dest remains 1 across later legal writes until rst.
- With REGWR_FWD_EN: write R7=32'h55, fwd_rs=7, fwd_rt=0 during the wrReg cycle -> fwd_hit1=1, fwd_hit2=0, fwd_data=32'h55.

Source files
------------

// File: rtl/regwr_arbiter.sv
// Round-robin scheduler for the single register-bank write port (ALU vs load).
// Define REGWR_FWD_EN to add the same-cycle write bypass compare outputs.
module regwr_arbiter #(
    parameter int unsigned NUM_REGS = 17,
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_dest,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_dest,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
`ifdef REGWR_FWD_EN
    input  logic [AW-1:0] fwd_rs,
    input  logic [AW-1:0] fwd_rt,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          wrReg,
    output logic [AW-1:0] destReg,
    output logic [DW-1:0] wrData,
    output logic          bad_dest,
    output logic          last_grant
);

    logic          grant_alu;
    logic          grant_ld;
    logic          xfer;
    logic [AW-1:0] sel_dest;
    logic [DW-1:0] sel_data;
    logic          dest_zero;
    logic          dest_oob;

    // Readies are forced low during reset so nothing is accepted then.
    assign grant_alu = !rst && alu_valid && (!ld_valid || last_grant);
    assign grant_ld  = !rst && ld_valid && !grant_alu;
    assign alu_ready = grant_alu;
    assign ld_ready  = grant_ld;
    assign xfer      = grant_alu || grant_ld;

    always_comb begin
        sel_dest = alu_dest;
        sel_data = alu_data;
        if (grant_ld) begin
            sel_dest = ld_dest;
            sel_data = ld_data;
        end
    end

    assign dest_zero = (sel_dest == '0);
    assign dest_oob  = (32'(sel_dest) >= NUM_REGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrReg      <= 1'b0;
            destReg    <= '0;
            wrData     <= '0;
            bad_dest   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            wrReg <= 1'b0;
            if (xfer) begin
                last_grant <= grant_ld;
                if (dest_oob) begin
                    bad_dest <= 1'b1;
                end else if (!dest_zero) begin
                    wrReg   <= 1'b1;
                    destReg <= sel_dest;
                    wrData  <= sel_data;
                end
            end
        end
    end

`ifdef REGWR_FWD_EN
    assign fwd_hit1 = wrReg && (destReg == fwd_rs) && (fwd_rs != '0);
    assign fwd_hit2 = wrReg && (destReg == fwd_rt) && (fwd_rt != '0);
    assign fwd_data = wrData;
`endif

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed vector bench for regwr_arbiter.
// Build with REGWR_FWD_EN defined to also exercise the bypass outputs.
module tb_regwr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_dest = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_dest = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        wrReg;
    logic [4:0]  destReg;
    logic [31:0] wrData;
    logic        bad_dest;
    logic        last_grant;
`ifdef REGWR_FWD_EN
    logic [4:0]  fwd_rs = '0;
    logic [4:0]  fwd_rt = '0;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regwr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_dest   (alu_dest),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_dest    (ld_dest),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
`ifdef REGWR_FWD_EN
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data   (fwd_data),
`endif
        .wrReg      (wrReg),
        .destReg    (destReg),
        .wrData     (wrData),
        .bad_dest   (bad_dest),
        .last_grant (last_grant)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  ldd;
        logic [31:0] ldat;
        logic        ear;
        logic        elr;
        logic        ewr;
        logic [4:0]  ed;
        logic [31:0] edat;
        logic        ebad;
        logic        elg;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_out(input string tag, input logic ewr,
                           input logic [4:0] ed, input logic [31:0] edat,
                           input logic ebad, input logic elg);
        chk({tag, " wrReg"}, 32'(wrReg), 32'(ewr));
        chk({tag, " destReg"}, 32'(destReg), 32'(ed));
        chk({tag, " wrData"}, wrData, edat);
        chk({tag, " bad_dest"}, 32'(bad_dest), 32'(ebad));
        chk({tag, " last_grant"}, 32'(last_grant), 32'(elg));
    endtask

    initial begin
        //        av ad     adat       lv ldd    ldat       ar lr wr ed     edat       bad lg
        v[0]  = '{1, 5'd3,  32'h1234,  0, 5'd0,  32'h0,     1, 0, 1, 5'd3,  32'h1234,  0, 0};
        v[1]  = '{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     0, 0, 0, 5'd3,  32'h1234,  0, 0};
        v[2]  = '{0, 5'd0,  32'h0,     1, 5'd9,  32'hCAFE,  0, 1, 1, 5'd9,  32'hCAFE,  0, 1};
        v[3]  = '{1, 5'd5,  32'hA,     1, 5'd5,  32'hB,     1, 0, 1, 5'd5,  32'hA,     0, 0};
        v[4]  = '{1, 5'd5,  32'hA,     1, 5'd5,  32'hB,     0, 1, 1, 5'd5,  32'hB,     0, 1};
        v[5]  = '{1, 5'd6,  32'hC,     1, 5'd7,  32'hD,     1, 0, 1, 5'd6,  32'hC,     0, 0};
        v[6]  = '{1, 5'd8,  32'hE,     1, 5'd7,  32'hD,     0, 1, 1, 5'd7,  32'hD,     0, 1};
        v[7]  = '{0, 5'd0,  32'h0,     1, 5'd0,  32'hFFFF,  0, 1, 0, 5'd7,  32'hD,     0, 1};
        v[8]  = '{1, 5'd20, 32'h99,    0, 5'd0,  32'h0,     1, 0, 0, 5'd7,  32'hD,     1, 0};
        v[9]  = '{1, 5'd16, 32'h77,    0, 5'd0,  32'h0,     1, 0, 1, 5'd16, 32'h77,    1, 0};
        v[10] = '{0, 5'd0,  32'h0,     1, 5'd31, 32'h5,     0, 1, 0, 5'd16, 32'h77,    1, 1};
        v[11] = '{0, 5'd0,  32'h0,     1, 5'd1,  32'h11,    0, 1, 1, 5'd1,  32'h11,    1, 1};

        @(negedge clk);
        chk("rst alu_ready", 32'(alu_ready), 32'd0);
        chk_out("rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            alu_valid = v[i].av;
            alu_dest  = v[i].ad;
            alu_data  = v[i].adat;
            ld_valid  = v[i].lv;
            ld_dest   = v[i].ldd;
            ld_data   = v[i].ldat;
            #1;
            chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(v[i].ear));
            chk($sformatf("v%0d ld_ready", i), 32'(ld_ready), 32'(v[i].elr));
            @(posedge clk);
            @(negedge clk);
            chk_out($sformatf("v%0d", i), v[i].ewr, v[i].ed, v[i].edat,
                    v[i].ebad, v[i].elg);
        end

        // Continuous contention: last_grant is 1, so ALU first, then alternate.
        alu_valid = 1'b1;
        alu_dest  = 5'd2;
        alu_data  = 32'hAAAA;
        ld_valid  = 1'b1;
        ld_dest   = 5'd2;
        ld_data   = 32'hBBBB;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("alt%0d alu_ready", k), 32'(alu_ready),
                32'((k % 2) == 0));
            chk($sformatf("alt%0d ld_ready", k), 32'(ld_ready),
                32'((k % 2) == 1));
            @(posedge clk);
            @(negedge clk);
            chk_out($sformatf("alt%0d", k), 1'b1, 5'd2,
                    ((k % 2) == 0) ? 32'hAAAA : 32'hBBBB, 1'b1,
                    1'((k % 2) == 1));
        end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle wrReg", 32'(wrReg), 32'd0);
        chk("idle wrData hold", wrData, 32'hBBBB);

`ifdef REGWR_FWD_EN
        alu_valid = 1'b1;
        alu_dest  = 5'd7;
        alu_data  = 32'h55;
        @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0;
        fwd_rs = 5'd7;
        fwd_rt = 5'd0;
        #1;
        chk("fwd hit1", 32'(fwd_hit1), 32'd1);
        chk("fwd hit2", 32'(fwd_hit2), 32'd0);
        chk("fwd data", fwd_data, 32'h55);
        @(posedge clk);
        @(negedge clk);
        chk("fwd hit1 idle", 32'(fwd_hit1), 32'd0);
`endif

        // Reset while a request is pending: no accept, no write afterwards.
        alu_valid = 1'b1;
        alu_dest  = 5'd4;
        alu_data  = 32'h4444;
        ld_valid  = 1'b1;
        ld_dest   = 5'd3;
        ld_data   = 32'h3333;
        rst = 1'b1;
        #1;
        chk("mid rst alu_ready", 32'(alu_ready), 32'd0);
        chk("mid rst ld_ready", 32'(ld_ready), 32'd0);
        chk_out("mid rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        #1;
        chk_out("post rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
